// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, bus
// request/response shapes and the address/word types used by fetch and decode.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_DONE  = 3'd3,
    FS_DRAIN = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

  // Instructions are word aligned; any set low bit is a misaligned PC.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction bus between the fetch stage (master) and the instruction
// memory/cache (slave): address phase, then data phase.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ireq_valid;
  logic [ADDR_WIDTH-1:0] ireq_addr;
  logic                  iresp_addr_ok;
  logic                  iresp_data_ok;
  logic [DATA_WIDTH-1:0] iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one bus transaction per fetch, result handed to
// decode via valid/ready. Optional misaligned-PC check: FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  flush,
  output logic                  ready_in,
  fetch_unit_if.master          ibus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_exc,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic addr_ok;
  logic data_ok;
  logic accept;
  logic skip_bus;
  logic capture;

  assign addr_ok = ibus.iresp_addr_ok;
  assign data_ok = ibus.iresp_data_ok;

  assign ready_in = (state_q == FS_IDLE) || ((state_q == FS_DONE) && out_ready);
  assign accept   = ready_in && start && !flush;

`ifdef FETCH_ALIGN_CHECK_EN
  assign skip_bus = is_misaligned(pc_in[1:0]);
`else
  assign skip_bus = 1'b0;
`endif

  // Data is kept only when it belongs to a fetch that is still wanted.
  assign capture = !flush && data_ok &&
                   (((state_q == FS_REQ) && addr_ok) || (state_q == FS_WAIT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE: begin
        if (accept) state_d = skip_bus ? FS_DONE : FS_REQ;
      end
      FS_REQ: begin
        if (addr_ok) begin
          if (data_ok) state_d = flush ? FS_IDLE : FS_DONE;
          else         state_d = flush ? FS_DRAIN : FS_WAIT;
        end else if (flush) begin
          state_d = FS_IDLE;
        end
      end
      FS_WAIT: begin
        if (data_ok)    state_d = flush ? FS_IDLE : FS_DONE;
        else if (flush) state_d = FS_DRAIN;
      end
      FS_DONE: begin
        if (accept)                  state_d = skip_bus ? FS_DONE : FS_REQ;
        else if (out_ready || flush) state_d = FS_IDLE;
      end
      FS_DRAIN: begin
        if (data_ok) state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) pc_q <= pc_in;
      if (accept && skip_bus) instr_q <= '0;
      else if (capture)       instr_q <= ibus.iresp_data;
      if (out_valid && out_ready) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic exc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q <= 1'b0;
    end else if (accept) begin
      exc_q <= skip_bus;
    end
  end

  assign out_exc = exc_q;
`else
  assign out_exc = 1'b0;
`endif

  assign ibus.ireq_valid = (state_q == FS_REQ);
  assign ibus.ireq_addr  = pc_q;
  assign out_valid       = (state_q == FS_DONE);
  assign out_instr       = instr_q;
  assign out_pc          = pc_q;
  assign busy            = (state_q != FS_IDLE);
  assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a transaction-level
// model of the fetch stage and a behavioural instruction memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, flush, out_ready;
  logic        ready_in, out_valid, out_exc, busy;
  addr_t       pc_in, out_pc;
  word_t       out_instr;
  logic [31:0] fetch_count;

  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ibus ();

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .flush(flush),
    .ready_in(ready_in), .ibus(ibus), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_exc(out_exc), .busy(busy), .fetch_count(fetch_count)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Bus responder controls: 0 never, 1 whenever legal, 2 random.
  int    ao_sel = 2;
  int    do_sel = 2;
  bit    bus_busy = 1'b0;
  addr_t bus_addr = '0;

  // Reference model: what the fetch stage owes the bus and decode.
  bit          m_issue, m_outst, m_disc, m_res, m_exc;
  addr_t       m_pc;
  word_t       m_instr;
  logic [31:0] m_cnt;

  function automatic word_t mem(input addr_t a);
    return a ^ 32'h9BC8_0001;
  endfunction

  function automatic bit pick(input int sel);
    if (sel == 1) return 1'b1;
    if (sel == 2) return $urandom_range(0, 99) < 40;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit st, input addr_t pc, input bit fl,
                              input bit ordy, input bit ao, input bit dok);
    bit rdy;
    if (r) begin
      m_issue = 0; m_outst = 0; m_disc = 0; m_res = 0; m_exc = 0; m_cnt = '0;
      return;
    end
    if (m_res && ordy) m_cnt = m_cnt + 1;
    if (m_issue) begin
      if (ao && dok) begin
        m_issue = 0;
        if (!fl) begin m_res = 1; m_instr = mem(m_pc); end
      end else if (ao) begin
        m_issue = 0; m_outst = 1; m_disc = fl;
      end else if (fl) begin
        m_issue = 0;
      end
    end else if (m_outst) begin
      if (dok) begin
        m_outst = 0;
        if (!(m_disc || fl)) begin m_res = 1; m_instr = mem(m_pc); end
        m_disc = 0;
      end else if (fl) begin
        m_disc = 1;
      end
    end else begin
      rdy = !m_res || ordy;
      if (m_res && (ordy || fl)) m_res = 0;
      if (rdy && st && !fl) begin
        m_pc  = pc;
        m_exc = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (pc[1:0] != 2'b00) begin
          m_res = 1; m_exc = 1; m_instr = '0;
        end else m_issue = 1;
`else
        m_issue = 1;
`endif
      end
    end
  endtask

  // One clock cycle: drive inputs, answer the bus, compare, advance model.
  task automatic step(input bit r, input bit st, input addr_t pc, input bit fl, input bit ordy);
    bit    ao, dok;
    addr_t snap;
    reset = r; start = st; pc_in = pc; flush = fl; out_ready = ordy;
    ao  = ibus.ireq_valid && pick(ao_sel);
    dok = (bus_busy || ao) && pick(do_sel);
    ibus.iresp_addr_ok = ao;
    ibus.iresp_data_ok = dok;
    ibus.iresp_data    = dok ? mem(bus_busy ? bus_addr : ibus.ireq_addr) : word_t'($urandom);
    #1;
    check("ready_in", ready_in, !m_issue && !m_outst && (!m_res || ordy));
    check("ireq_valid", ibus.ireq_valid, m_issue);
    if (m_issue) check("ireq_addr", ibus.ireq_addr, m_pc);
    check("out_valid", out_valid, m_res);
    check("busy", busy, m_issue || m_outst || m_res);
    check("fetch_count", fetch_count, m_cnt);
    if (m_res) begin
      check("out_pc", out_pc, m_pc);
      check("out_instr", out_instr, m_instr);
      check("out_exc", out_exc, m_exc);
    end
`ifndef FETCH_ALIGN_CHECK_EN
    check("out_exc_tied", out_exc, 1'b0);
`endif
    snap = ibus.ireq_addr;
    @(posedge clk);
    #1;
    model_update(r, st, pc, fl, ordy, ao, dok);
    if (r || dok) bus_busy = 1'b0;
    else if (ao) begin bus_busy = 1'b1; bus_addr = snap; end
    @(negedge clk);
  endtask

  initial begin
    addr_t rpc;
    reset = 1; start = 0; flush = 0; out_ready = 0; pc_in = '0;
    ibus.iresp_addr_ok = 0; ibus.iresp_data_ok = 0; ibus.iresp_data = '0;
    m_issue = 0; m_outst = 0; m_disc = 0; m_res = 0; m_exc = 0; m_pc = '0; m_instr = '0; m_cnt = '0;
    @(negedge clk);
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    check("rst_ireq_addr", ibus.ireq_addr, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_valid", out_valid, 1'b0);

    // Zero-wait fetch: out_valid two cycles after start.
    ao_sel = 1; do_sel = 1;
    step(0, 1, 32'hBFC0_0000, 0, 0);
    check("zw_lat1_valid", out_valid, 1'b0);
    step(0, 0, '0, 0, 0);
    check("zw_valid", out_valid, 1'b1);
    check("zw_instr", out_instr, 32'h2408_0001);
    check("zw_pc", out_pc, 32'hBFC0_0000);
    step(0, 0, '0, 0, 1);
    check("zw_count", fetch_count, 32'd1);

    // Slow bus: addr_ok after 3 REQ cycles, data_ok 4 cycles later.
    ao_sel = 0; do_sel = 0;
    step(0, 1, 32'hBFC0_0010, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0);
    ao_sel = 1;
    step(0, 0, '0, 0, 0);
    ao_sel = 0;
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0);
    check("slow_no_valid", out_valid, 1'b0);
    do_sel = 1;
    step(0, 0, '0, 0, 0);
    check("slow_instr", out_instr, mem(32'hBFC0_0010));

    // Back-to-back: handshake and new start in the same DONE cycle.
    step(0, 1, 32'hBFC0_0004, 0, 1);
    check("b2b_req", ibus.ireq_valid, 1'b1);
    check("b2b_addr", ibus.ireq_addr, 32'hBFC0_0004);
    check("b2b_count", fetch_count, 32'd2);
    ao_sel = 1;
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);

    // Flush in WAIT, data arrives two cycles later and is dropped.
    ao_sel = 1; do_sel = 0;
    step(0, 1, 32'hBFC0_0020, 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    ao_sel = 0;
    step(0, 1, 32'hBFC0_0030, 0, 0);
    check("drain_busy", busy, 1'b1);
    check("drain_ready", ready_in, 1'b0);
    do_sel = 1;
    step(0, 0, '0, 0, 0);
    check("drain_idle", busy, 1'b0);
    check("drain_no_valid", out_valid, 1'b0);

    // Reset while waiting for data.
    ao_sel = 1; do_sel = 0;
    step(0, 1, 32'hBFC0_0040, 0, 0);
    step(0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", fetch_count, 32'd0);
    check("midrst_pc", out_pc, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    ao_sel = 1; do_sel = 1;
    step(0, 1, 32'hBFC0_0002, 0, 0);
    check("mis_noreq", ibus.ireq_valid, 1'b0);
    check("mis_valid", out_valid, 1'b1);
    check("mis_exc", out_exc, 1'b1);
    check("mis_pc", out_pc, 32'hBFC0_0002);
    step(0, 0, '0, 0, 1);
`endif

    // Randomized traffic.
    ao_sel = 2; do_sel = 2;
    for (int i = 0; i < 3000; i++) begin
      rpc = addr_t'($urandom);
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60, rpc,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multi-cycle reference CPU, directly upstream of decode.
- Takes a PC from the control FSM and runs one instruction-bus transaction (address phase, then data phase).
- Presents the fetched word plus its PC to decode through a valid/ready handshake.
- Supports flush: in-flight transactions are drained safely, never abandoned mid-bus.

Parameters:
- ADDR_WIDTH, 32, PC / bus address width.
- DATA_WIDTH, 32, instruction word width.
- CNT_WIDTH, 32, width of the retired-fetch counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a fetch of pc_in; sampled when ready_in=1.
- pc_in  in  ADDR_WIDTH  fetch address.
- flush  in  1  discard current/pending fetch.
- ready_in  out  1  high in IDLE, and in DONE while out_ready=1.
- ireq_valid  out  1  bus address-phase valid.
- ireq_addr  out  ADDR_WIDTH  bus address (latched pc).
- iresp_addr_ok  in  1  address phase accepted.
- iresp_data_ok  in  1  data returned.
- iresp_data  in  DATA_WIDTH  instruction word.
- out_valid  out  1  instr/pc valid for decode.
- out_ready  in  1  decode accepts.
- out_instr  out  DATA_WIDTH  fetched instruction.
- out_pc  out  ADDR_WIDTH  PC of out_instr.
- out_exc  out  1  misaligned-PC exception; only with FETCH_ALIGN_CHECK_EN, else tied 0.
- busy  out  1  state != IDLE.
- fetch_count  out  CNT_WIDTH  out handshakes since reset; wraps.

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN. Encoding is in the shared package.
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE.
  - ireq_valid=0, out_valid=0, out_exc=0.
  - out_instr, out_pc, ireq_addr = 0.
  - fetch_count=0.
  - Reset mid-transaction drops all state; the bus resets in the same cycle.
- IDLE:
  - start && !flush: latch pc_in, go to REQ.
  - flush has priority over start.
- REQ:
  - ireq_valid=1, ireq_addr=latched pc.
  - addr_ok && data_ok in the same cycle: capture data, go to DONE.
  - addr_ok only: go to WAIT.
  - Otherwise stay in REQ; address is held stable.
- WAIT: on data_ok, capture iresp_data into out_instr and go to DONE.
- DONE:
  - out_valid=1; out_instr and out_pc are held stable until out_ready.
  - out_ready && start && !flush: latch new pc, go to REQ (back-to-back, no idle bubble).
  - out_ready only: go to IDLE.
  - fetch_count += 1 on every out_valid && out_ready.
- Minimum latency: start → out_valid is 2 cycles (start cycle, then REQ with addr_ok+data_ok, then DONE).
- Flush, per state:
  - IDLE/DONE: go to IDLE. out_valid drops next cycle; no count increment unless out_ready was high in the same cycle (the handshake completes first).
  - REQ without addr_ok: go to IDLE. Withdrawing an unaccepted request is permitted by the bus protocol.
  - REQ with addr_ok and no data_ok: go to DRAIN.
  - REQ with addr_ok and data_ok: go to IDLE.
  - WAIT without data_ok: go to DRAIN.
  - WAIT with data_ok: go to IDLE, data discarded.
- DRAIN:
  - ireq_valid=0, ready_in=0, start ignored.
  - On data_ok, discard the data and go to IDLE.
  - flush in DRAIN has no further effect.
- The bus never has more than one outstanding transaction.
- out_* are driven from registers, with no combinational path from iresp_*.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - On start with pc_in[1:0] != 0, skip the bus and go straight to DONE next cycle.
  - In that DONE: out_exc=1, out_instr=0, out_pc=pc_in.
  - The handshake and counter behave as for a normal fetch.
  - out_exc clears when the next fetch is accepted.
- Undefined:
  - No check; the address is issued as-is.
  - out_exc is a constant 0.

Decomposition:
- Shared package (defs):
  - fetch_state_t enum (IDLE, REQ, WAIT, DONE, DRAIN).
  - Bus request/response typedefs (valid/addr; addr_ok/data_ok/data).
  - addr_t / word_t.
- No sub-module required. The counter stays inline.

Test Plan:
- Single fetch, zero-wait bus:
  - Stimulus: start, pc_in=0xBFC00000; addr_ok and data_ok both high in the REQ cycle with data=0x24080001.
  - Response: out_valid 2 cycles after start, out_instr=0x24080001, out_pc=0xBFC00000, fetch_count=1 after out_ready.
- Slow bus:
  - Stimulus: addr_ok after 3 cycles, data_ok 4 cycles later.
  - Response: ireq_addr stable throughout REQ; ireq_valid falls after addr_ok; out_valid only after data_ok.
- Back-to-back:
  - Stimulus: in DONE, out_ready=1 with start=1, pc_in=0xBFC00004.
  - Response: REQ next cycle with no IDLE cycle; fetch_count increments by 1.
- Flush in WAIT:
  - Stimulus: flush in WAIT, then data_ok 2 cycles later with data=0xDEADBEEF.
  - Response: DRAIN, busy=1, start ignored; data discarded; IDLE after data_ok; out_valid never asserted.
- Reset mid-fetch:
  - Stimulus: reset while in WAIT.
  - Response: next cycle state=IDLE, all outputs at reset values, fetch_count=0.
- Misaligned PC (FETCH_ALIGN_CHECK_EN):
  - Stimulus: start, pc_in=0xBFC00002.
  - Response: ireq_valid stays 0; next cycle out_valid=1, out_exc=1, out_pc=0xBFC00002.
